// File: rtl/step_pulse_gen.sv
// step_pulse_gen: stepper-motor step/direction generator.
// Turns a pulse period (in clk cycles) plus direction and run request into a
// registered drv_step waveform with a fixed high time, a minimum low time, and
// a direction setup gap before the first rise after any direction change.
// Also keeps a wrapping signed step position counter.
// Optional macro RAMP_EN: acceleration limiting (period may shrink by at most
// RAMP_STEP per pulse, starting from START_PERIOD after each IDLE).
module step_pulse_gen #(
  parameter int WIDTH_N      = 17,
  parameter int PULSE_WIDTH  = 50,
  parameter int DIR_SETUP    = 10,
  parameter int POS_W        = 32,
  parameter int RAMP_STEP    = 200,
  parameter int START_PERIOD = 80000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               dir_in,
  input  logic [WIDTH_N-1:0] period,
  output logic               step,
  output logic               dir_out,
  output logic               busy,
  output logic [POS_W-1:0]   step_pos
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DSETUP = 2'd1,
    S_HIGH   = 2'd2,
    S_LOW    = 2'd3
  } state_e;

  localparam logic [WIDTH_N-1:0] PW_W  = WIDTH_N'(PULSE_WIDTH);
  localparam logic [WIDTH_N-1:0] DS_W  = WIDTH_N'(DIR_SETUP);
  localparam logic [WIDTH_N-1:0] MIN_P = WIDTH_N'(2 * PULSE_WIDTH);

  // Reject parameter sets the counters cannot represent.
  if (PULSE_WIDTH < 1 || DIR_SETUP < 1 || RAMP_STEP < 0 ||
      2 * PULSE_WIDTH >= 2 ** WIDTH_N || START_PERIOD >= 2 ** WIDTH_N) begin : g_bad_params
    $error("step_pulse_gen: parameters out of range");
  end

  state_e             state_q, state_d;
  logic [WIDTH_N-1:0] cnt_q, cnt_d;      // cycles spent in the current state
  logic [WIDTH_N-1:0] p_q, p_d;          // period latched for the current pulse
  logic               dir_q, dir_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               step_q, busy_q;

  logic               enter_high;
  logic [WIDTH_N-1:0] target_p;          // requested period clamped to the minimum
  logic [WIDTH_N-1:0] p_new;             // period to latch on the next HIGH entry
  logic [WIDTH_N-1:0] low_last;          // cnt value of the final LOW cycle

  assign target_p = (period > MIN_P) ? period : MIN_P;
  assign low_last = p_q - PW_W - 1'b1;

`ifdef RAMP_EN
  localparam logic [WIDTH_N-1:0] RAMP_W  = WIDTH_N'(RAMP_STEP);
  localparam logic [WIDTH_N-1:0] START_W = WIDTH_N'(START_PERIOD);

  logic               first_q, first_d;  // next HIGH entry is the first since IDLE
  logic [WIDTH_N-1:0] ramp_floor;

  // Shortest period allowed for the next pulse, limited by the acceleration ramp.
  always_comb begin
    ramp_floor = (p_q > RAMP_W) ? (p_q - RAMP_W) : '0;
    if (first_q) begin
      p_new = (target_p > START_W) ? target_p : START_W;
    end else begin
      p_new = (target_p > ramp_floor) ? target_p : ramp_floor;
    end
  end

  // Ramp restarts from START_PERIOD whenever the generator goes idle.
  always_comb begin
    first_d = first_q;
    if (state_d == S_IDLE) begin
      first_d = 1'b1;
    end else if (enter_high) begin
      first_d = 1'b0;
    end
  end

  // Ramp state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b1;
    end else begin
      first_q <= first_d;
    end
  end
`else
  assign p_new = target_p;
`endif

  // Next-state logic: pulse sequencing, period latch, direction and position.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    p_d        = p_q;
    dir_d      = dir_q;
    pos_d      = pos_q;
    enter_high = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable && (period != '0)) begin
          if (dir_in != dir_q) begin
            dir_d   = dir_in;
            state_d = S_DSETUP;
          end else begin
            state_d    = S_HIGH;
            enter_high = 1'b1;
          end
        end
      end

      S_DSETUP: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DS_W - 1'b1) begin
          state_d    = S_HIGH;
          cnt_d      = '0;
          enter_high = 1'b1;
        end
      end

      S_HIGH: begin
        // High time is never cut short by input changes.
        if (cnt_q == PW_W - 1'b1) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      end

      S_LOW: begin
        if (cnt_q == low_last) begin
          cnt_d = '0;
          if (!enable || (period == '0)) begin
            state_d = S_IDLE;
          end else if (dir_in != dir_q) begin
            dir_d   = dir_in;
            state_d = S_DSETUP;
          end else begin
            state_d    = S_HIGH;
            enter_high = 1'b1;
          end
        end else if (!enable && (cnt_q >= PW_W - 1'b1)) begin
          // Early stop, but only after a full PULSE_WIDTH of low time.
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enter_high) begin
      p_d   = p_new;
      pos_d = dir_q ? (pos_q + 1'b1) : (pos_q - 1'b1);
    end
  end

  // State and output registers; step and busy come straight from flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      step_q  <= (state_d == S_HIGH);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign step     = step_q;
  assign dir_out  = dir_q;
  assign busy     = busy_q;
  assign step_pos = pos_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Testbench for step_pulse_gen: timeline-based reference model compared every
// cycle, directed scenarios with hand-computed waveform timings, then random runs.
module tb_step_pulse_gen;

  localparam int WIDTH_N = 17;
  localparam int PW      = 50;
  localparam int DS      = 10;
  localparam int POS_W   = 8;
  localparam int RS      = 200;
  localparam int SP      = 1000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               dir_in = 1'b0;
  logic [WIDTH_N-1:0] period = '0;
  logic               step, dir_out, busy;
  logic [POS_W-1:0]   step_pos;

  step_pulse_gen #(
    .WIDTH_N(WIDTH_N), .PULSE_WIDTH(PW), .DIR_SETUP(DS), .POS_W(POS_W),
    .RAMP_STEP(RS), .START_PERIOD(SP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .dir_in(dir_in), .period(period),
    .step(step), .dir_out(dir_out), .busy(busy), .step_pos(step_pos)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model (pulse timeline) ----------------
  localparam int M_IDLE = 0, M_SETUP = 1, M_PULSE = 2;
  int             mn = 0;        // index of the cycle now being entered
  int             m_mode = M_IDLE;
  int             m_t0 = 0;      // first high cycle of current pulse
  int             m_s0 = 0;      // first cycle of direction setup gap
  int             m_p = 0;       // period of current pulse
  int             m_prev = SP;
  bit             m_first = 1'b1;
  logic           m_dir = 1'b0;
  logic [POS_W-1:0] m_pos = '0;
  logic           exp_step = 1'b0, exp_busy = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task start_pulse();
    int eff;
    eff = imax(int'(period), 2 * PW);
`ifdef RAMP_EN
    m_p = m_first ? imax(eff, SP) : imax(eff, m_prev - RS);
    m_prev = m_p;
    m_first = 1'b0;
`else
    m_p = eff;
`endif
    m_t0 = mn;
    m_mode = M_PULSE;
    m_pos = m_dir ? m_pos + 1'b1 : m_pos - 1'b1;
  endtask

  task go_idle();
    m_mode = M_IDLE;
    m_first = 1'b1;
    m_prev = SP;
  endtask

  always @(posedge clk) begin : model
    int k;
    mn++;
    if (rst) begin
      go_idle();
      m_dir = 1'b0;
      m_pos = '0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (enable && period != 0) begin
            if (dir_in != m_dir) begin
              m_dir = dir_in; m_mode = M_SETUP; m_s0 = mn;
            end else start_pulse();
          end
        end
        M_SETUP: begin
          if (!enable) go_idle();
          else if (mn - 1 - m_s0 == DS - 1) start_pulse();
        end
        default: begin
          k = mn - 1 - m_t0;                 // offset of the cycle just ended
          if (k >= PW) begin
            if (k == m_p - 1) begin
              if (!enable || period == 0) go_idle();
              else if (dir_in != m_dir) begin
                m_dir = dir_in; m_mode = M_SETUP; m_s0 = mn;
              end else start_pulse();
            end else if (!enable && (k - PW + 1) >= PW) begin
              go_idle();
            end
          end
        end
      endcase
    end
    exp_step = (m_mode == M_PULSE) && (mn - m_t0 < PW);
    exp_busy = (m_mode != M_IDLE);
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("step", step, exp_step);
      check("busy", busy, exp_busy);
      check("dir_out", dir_out, m_dir);
      check("step_pos", step_pos, m_pos);
    end
  end

  // ---------------- waveform monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int   rises[$];
  int   high_len = 0, last_high_len = -1, fall_cyc = -1, idle_cyc = -1;
  logic prev_step = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    if (step && !prev_step) rises.push_back(cyc);
    if (step) high_len++;
    else if (prev_step) begin
      last_high_len = high_len; high_len = 0; fall_cyc = cyc;
    end
    if (prev_busy && !busy) idle_cyc = cyc;
    prev_step = step;
    prev_busy = busy;
  end

  function automatic int rise_at(input int i);
    if (i >= 0 && i < rises.size()) return rises[i];
    return -1000000;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_rise(input string name, input int budget);
    int  n0;
    bit  ok;
    n0 = rises.size();
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (rises.size() > n0) ok = 1'b1;
    end
    check(name, ok, 1'b1);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int c0, n;
    cycles(2);
    chk_en = 1'b1;
    check("reset_step", step, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_pos", step_pos, '0);
    check("reset_dir", dir_out, 1'b0);

    // A: steady run, period 800, reverse direction
    rst = 1'b0; enable = 1'b1; dir_in = 1'b0; period = 17'd800;
    c0 = cyc;
    rises.delete();
    cycles(1700);
    check("A_rise_count", rises.size(), 3);
    check("A_first_rise_latency", rise_at(0) - c0, 1);
    check("A_spacing", rise_at(2) - rise_at(1), 800);
    check("A_high_len", last_high_len, PW);
    check("A_pos_minus3", step_pos, 8'hFD);
    check("A_busy", busy, 1'b1);

    // B: direction change requested mid-LOW
    rises.delete();
    wait_rise("B_rise_timeout", 2000);
    cycles(200);
    dir_in = 1'b1;
    cycles(1000);
    check("B_spacing_dir_change", rise_at(1) - rise_at(0), 800 + DS);
    check("B_dir_out", dir_out, 1'b1);

    // C: period below minimum is clamped
    period = 17'd60;
    rises.delete();
    cycles(2000);
    check("C_spacing_clamped", rise_at(rises.size() - 1) - rise_at(rises.size() - 2), 2 * PW);
    check("C_high_len", last_high_len, PW);

    // D: enable dropped 20 cycles into a high pulse
    period = 17'd800;
    rises.delete();
    wait_rise("D_rise_timeout", 2000);
    cycles(19);
    enable = 1'b0;
    cycles(300);
    check("D_high_not_truncated", last_high_len, PW);
    check("D_min_low_then_idle", idle_cyc - fall_cyc, PW);
    check("D_busy_low", busy, 1'b0);
    check("D_no_more_rises", rises.size(), 1);

    // E: period 0 means no motion, then reset mid-HIGH
    enable = 1'b1; period = '0;
    rises.delete();
    cycles(100);
    check("E_no_rises", rises.size(), 0);
    check("E_busy", busy, 1'b0);
    period = 17'd800;
    wait_rise("E_rise_timeout", 2000);
    cycles(10);
    rst = 1'b1;
    cycles(1);
    check("E_rst_step", step, 1'b0);
    check("E_rst_pos", step_pos, '0);
    check("E_rst_busy", busy, 1'b0);
    rst = 1'b0; enable = 1'b0;
    cycles(2);

`ifdef RAMP_EN
    // R: acceleration ramp from START_PERIOD down to the requested period
    rst = 1'b1;
    cycles(2);
    rst = 1'b0; enable = 1'b1; dir_in = 1'b0; period = 17'd400;
    rises.delete();
    cycles(3300);
    check("R_sp1", rise_at(1) - rise_at(0), 1000);
    check("R_sp2", rise_at(2) - rise_at(1), 800);
    check("R_sp3", rise_at(3) - rise_at(2), 600);
    check("R_sp4", rise_at(4) - rise_at(3), 400);
    check("R_sp5", rise_at(5) - rise_at(4), 400);
    enable = 1'b0;
    cycles(200);
`endif

    // Random: model-checked every cycle
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        cycles($urandom_range(1, 3));
        rst = 1'b0;
      end
      enable = ($urandom_range(0, 4) != 0);
      dir_in = 1'($urandom_range(0, 1));
      period = ($urandom_range(0, 7) == 0) ? '0 : WIDTH_N'($urandom_range(20, 900));
      n = $urandom_range(20, 1200);
      cycles(n);
    end
    enable = 1'b0;
    cycles(1000);
    check("final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
